// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller: operation codes, FSM states
// and a small decode helper.
package mem_pkg;

    // Request operation codes carried on req_op.
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INC   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Controller FSM states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StCap  = 3'd2,
        StWr   = 3'd3,
        StRsp  = 3'd4
    } state_e;

    // True for operations that start with a memory read.
    function automatic logic op_reads_mem(input op_e op);
        return (op == OP_READ) || (op == OP_INC);
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Request/response front end for a single-port synchronous data memory.
// Sequences READ, WRITE and read-modify-write INC through a Moore FSM and
// drives the active-low memory strobes directly.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_mrd,
    output logic              mem_mwr,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    // Holds the captured read value and doubles as the response data register.
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;
    op_e               req_op_dec;

    assign req_op_dec = op_e'(req_op);
    assign accept     = req_valid && req_ready;

    // Next-state logic and request/read-data capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = req_op_dec;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (op_reads_mem(req_op_dec)) begin
                        state_d = StRd;
                    end else if (req_op_dec == OP_WRITE) begin
                        state_d = StWr;
                    end else begin
                        // Reserved op: consumed by the handshake, otherwise ignored.
                        state_d = StIdle;
                    end
                end
            end
            StRd: begin
                state_d = StCap;
            end
            StCap: begin
                rdata_d = mem_read_data;
                state_d = (op_q == OP_INC) ? StWr : StRsp;
            end
            StWr: begin
                if (op_q == OP_WRITE) begin
                    rdata_d = '0;
                end
                state_d = StRsp;
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= StIdle;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from state; strobes and ready are masked by clr so nothing
    // reaches the memory or the requester while the clear is applied.
    always_comb begin
        req_ready      = clr && (state_q == StIdle);
        rsp_valid      = (state_q == StRsp);
        rsp_data       = rdata_q;
        mem_mrd        = !(clr && (state_q == StRd));
        mem_mwr        = !(clr && (state_q == StWr));
        mem_address    = '0;
        mem_write_data = '0;
        if ((state_q == StRd) || (state_q == StWr)) begin
            mem_address = addr_q;
        end
        if (state_q == StWr) begin
            mem_write_data = (op_q == OP_INC) ? rdata_q + DATA_W'(1) : wdata_q;
        end
    end

    // The two strobes are mutually exclusive by construction.
    assert property (@(posedge clk) !(!mem_mrd && !mem_mwr));

    // Response data may not change while the consumer is stalling.
    assert property (@(posedge clk) disable iff (!clr)
                     (rsp_valid && !rsp_ready) |=> (rsp_data == $past(rsp_data)));

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, giving the word-address width.
REQ-002 SHALL have parameter DATA_W, default 4, giving the data word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1, synchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-007 SHALL have port req_op, input, 2, operation: 00 READ, 01 WRITE, 10 INC, 11 reserved.
REQ-008 SHALL have port req_addr, input, ADDR_W, target word address.
REQ-009 SHALL have port req_wdata, input, DATA_W, write data, used for WRITE only.
REQ-010 SHALL have port rsp_valid, output, 1, response present.
REQ-011 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-012 SHALL have port rsp_data, output, DATA_W: read value for READ/INC, 0 for WRITE.
REQ-013 SHALL have port mem_address, output, ADDR_W, memory address.
REQ-014 SHALL have port mem_write_data, output, DATA_W, memory write data.
REQ-015 SHALL have port mem_mrd, output, 1, active-low memory read strobe.
REQ-016 SHALL have port mem_mwr, output, 1, active-low memory write strobe.
REQ-017 SHALL have port mem_read_data, input, DATA_W, memory read data, registered by the memory one edge after mem_mrd is low.

Function
REQ-018 SHALL implement a Moore FSM with states IDLE, RD, CAP, WR and RSP.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1, latching op, addr and wdata.
REQ-020 SHALL transition from IDLE to RD for READ/INC, to WR for WRITE, and stay in IDLE, dropping the request, for op 11.
REQ-021 SHALL drive mem_mrd=0 only in RD and mem_mwr=0 only in WR; both SHALL be 1 in every other state and never 0 together.
REQ-022 SHALL drive mem_address from the latched address in RD and WR, and 0 elsewhere.
REQ-023 SHALL go RD->CAP unconditionally; in CAP it SHALL register mem_read_data into rsp_data.
REQ-024 SHALL go CAP->RSP for READ and CAP->WR for INC.
REQ-025 SHALL drive mem_write_data as latched wdata for WRITE, and as (captured value + 1) mod 2^DATA_W for INC; INC SHALL return the old value.
REQ-026 SHALL go WR->RSP unconditionally; WRITE SHALL set rsp_data=0.
REQ-027 SHALL assert rsp_valid only in RSP, holding rsp_data stable until the edge where rsp_ready=1, then go to IDLE.
REQ-028 SHALL have these latencies from the accept edge to the first cycle with rsp_valid=1: READ 3 edges, WRITE 2 edges, INC 4 edges.
REQ-029 SHALL allow back-to-back operation: the next request can be accepted on the first edge after the response handshake.

Reset
REQ-030 SHALL, on any edge with clr=0, enter IDLE and set rsp_valid=0, rsp_data=0, mem_mrd=1, mem_mwr=1, mem_address=0 and mem_write_data=0, regardless of the current state.
REQ-031 SHALL abandon a reset mid-operation with no memory strobe issued in the reset cycle or in the first cycle after clr returns to 1.
REQ-032 SHALL hold req_ready=0 while clr=0.

Structure
REQ-033 SHALL take its op encodings (OP_READ, OP_WRITE, OP_INC) and FSM state encodings from a shared package/defines file, mem_pkg.
REQ-034 SHALL contain no sub-module; it sits directly upstream of the data memory, wired port-to-port, with the same clk and clr.

Verification
REQ-035 SHALL be verified for READ: after clear (memory holds mem[i]=i), READ addr 7 -> rsp_valid 3 edges after accept with rsp_data=7, and mem_mrd low exactly one cycle.
REQ-036 SHALL be verified for WRITE then READ: WRITE 11 to addr 5 -> mem_mwr low exactly one cycle and rsp_data=0; then READ addr 5 -> rsp_data=11.
REQ-037 SHALL be verified for INC with wrap-around: INC addr 15 -> rsp_data=15; then READ 15 -> 0; INC addr 3 twice -> responses 3 and 4.
REQ-038 SHALL be verified for backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data held stable and req_ready=0 throughout; a second req_valid is not accepted until after the handshake.
REQ-039 SHALL be verified for reset mid-operation: clr=0 while in WR of an INC -> next cycle IDLE with mem_mwr=1 and rsp_valid=0, and the memory location is not written.
REQ-040 SHALL be verified for the reserved op: op 11 with req_valid=1 -> accepted, no strobe, no response, and req_ready remains 1.
